xcalc_scheduler: RTL
====================

Name: xcalc_scheduler

Overview:
Frame-level sequencer for the x_calculate datapath in the MIMO detector.
- Buffers one channel matrix H (4x4 complex, Q8.8) and one Y vector (8 complex words).
- Runs x_calculate once per candidate index q = 0..NUM_Q-1: pulses start_new_q, replays H and Y, waits for q_done, then hands each result to a downstream consumer through a valid/ready handshake.

Parameters:
N, 16, word width of each real/imag sample (Q8.8 two's complement)
NUM_Q, 16, number of q indices swept per frame
H_ELEMS, 16, complex H words per q (row-major 4x4)
Y_ELEMS, 8, complex Y words per q
TIMEOUT_CYC, 1024, q_done watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
h_wr_valid  in  1  write next H word into buffer
h_wr_r, h_wr_i  in  N each  H word real/imag
y_wr_valid  in  1  write next Y word into buffer
y_wr_r, y_wr_i  in  N each  Y word real/imag
start  in  1  begin frame (single-cycle)
buf_full  out  1  H and Y buffers both complete
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last result accepted
xc_start_new_q  out  1  to x_calculate start_new_q
xc_q_index  out  4  to x_calculate q_index
xc_H_in_valid, xc_H_in_r, xc_H_in_i  out  1/N/N  H stream
xc_Y_in_valid, xc_Y_in_r, xc_Y_in_i  out  1/N/N  Y stream
xc_q_done  in  1  from x_calculate q_done
xc_xI1, xc_xQ1, xc_xI2, xc_xQ2  in  N each  x_calculate results
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_q_index  out  4  q of presented result
res_xI1, res_xQ1, res_xI2, res_xQ2  out  N each  captured results

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; write pointers 0; q counter 0; sticky done flag 0.
- Buffer load:
  - Writes are accepted only in IDLE. Each pointer auto-increments.
  - A write when the pointer is already at H_ELEMS or Y_ELEMS is ignored, with no wrap.
  - buf_full = (h_ptr==H_ELEMS) && (y_ptr==Y_ELEMS).
  - Writes outside IDLE are ignored.
- start is accepted only in IDLE with buf_full=1; otherwise it is ignored with no error. Acceptance sets busy=1 on the next cycle.
- FSM: IDLE -> START -> STREAM -> WAIT_DONE -> EMIT -> (START | FINISH) -> IDLE.
- START (1 cycle): xc_start_new_q=1, xc_q_index=q; clear the sticky done flag.
- STREAM (exactly H_ELEMS cycles, k=0..15):
  - xc_H_in_valid=1 with H[k].
  - xc_Y_in_valid=1 with Y[k] for k<Y_ELEMS, else 0 with data held 0.
  - Both streams start in the same cycle.
- xc_q_done is latched into the sticky flag in any state after START, so a done arriving during STREAM is not lost.
- WAIT_DONE: when xc_q_done or the sticky flag is set, capture xc_x* and q into the res_* registers and go to EMIT. If both are already true on entry, capture in that first cycle.
- EMIT:
  - res_valid=1; res_* stay stable until res_valid && res_ready.
  - On acceptance: if q==NUM_Q-1 go to FINISH, else q+1 and go to START.
  - res_ready while res_valid=0 has no effect.
- FINISH (1 cycle): frame_done=1. Then busy=0, q=0, both pointers=0 so buf_full=0, and return to IDLE.
- start during busy is ignored.
- Minimum latency per q, with done arriving during STREAM and res_ready tied high: 1 + 16 + 1 + 1 = 19 cycles. A full frame is therefore ≥ 16*19 + 1 cycles.
- Reset asserted mid-frame aborts immediately to the reset state. No partial frame_done is produced.

Optional Feature:
XSCHED_TIMEOUT_EN
- Defined:
  - Adds output timeout_err (1 bit, sticky until reset) and a cycle counter cleared in START.
  - If WAIT_DONE persists for TIMEOUT_CYC cycles, the block sets timeout_err, skips EMIT for that q and advances as if the result had been accepted.
- Undefined: no port, no counter; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package xcalc_pkg: N default, NUM_Q, H_ELEMS, Y_ELEMS, state enum typedef, and a complex-sample struct {r,i}.
- One natural sub-module, xcalc_sample_buf: dual write-pointer register file (H 16 and Y 8 entries) with read address k and full flags.

Test Plan:
- Load H[k]=(k<<8)+j(-k<<8) and Y per the standard 8-word vector, pulse start, model returns q_done 3 cycles after the last H word -> 16 results, res_q_index 0..15 in order; H replay is bit-exact each q; exactly one frame_done.
- Model asserts q_done during STREAM cycle k=10 -> the sticky flag is captured; WAIT_DONE lasts 1 cycle; the result equals the model outputs at the done cycle.
- res_ready held low 20 cycles on q=5 -> res_* stable throughout; no xc_start_new_q until acceptance.
- start with only 15 H words loaded -> ignored, busy stays 0; a 17th H write after a full buffer -> buffer unchanged.
- Reset pulse during STREAM of q=7 -> all outputs 0 within the reset; after reload and start, sweep restarts at q=0.
- With XSCHED_TIMEOUT_EN, model never asserts done for q=2 -> timeout_err=1 after 1024 cycles; q=2 result is absent; q=3..15 complete; frame_done still pulses.

Source files
------------

// File: rtl/xcalc_pkg.sv
// Shared sizes, FSM state type and complex sample type for the x_calculate frame sequencer.
package xcalc_pkg;

  localparam int unsigned N           = 16;
  localparam int unsigned NUM_Q       = 16;
  localparam int unsigned H_ELEMS     = 16;
  localparam int unsigned Y_ELEMS     = 8;
  localparam int unsigned TIMEOUT_CYC = 1024;

  localparam int unsigned Q_W  = $clog2(NUM_Q);
  localparam int unsigned K_W  = $clog2(H_ELEMS);
  localparam int unsigned YK_W = $clog2(Y_ELEMS);
  localparam int unsigned HP_W = $clog2(H_ELEMS + 1);
  localparam int unsigned YP_W = $clog2(Y_ELEMS + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_EMIT,
    S_FINISH
  } xc_state_t;

  typedef struct packed {
    logic [N-1:0] r;
    logic [N-1:0] i;
  } cplx_t;

endpackage

// File: rtl/xcalc_sample_buf.sv
// H (H_ELEMS) and Y (Y_ELEMS) sample register file with auto-incrementing,
// non-wrapping write pointers and a shared replay address.
module xcalc_sample_buf
  import xcalc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic           clear,
  input  logic           h_wr_valid,
  input  cplx_t          h_wr_data,
  input  logic           y_wr_valid,
  input  cplx_t          y_wr_data,
  input  logic [K_W-1:0] rd_k,
  output cplx_t          h_rd,
  output cplx_t          y_rd,
  output logic           h_full,
  output logic           y_full
);

  cplx_t            h_mem [H_ELEMS];
  cplx_t            y_mem [Y_ELEMS];
  logic [HP_W-1:0]  h_ptr;
  logic [YP_W-1:0]  y_ptr;

  assign h_full = (h_ptr == HP_W'(H_ELEMS));
  assign y_full = (y_ptr == YP_W'(Y_ELEMS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_ptr <= '0;
      y_ptr <= '0;
      for (int unsigned e = 0; e < H_ELEMS; e++) h_mem[e] <= '0;
      for (int unsigned e = 0; e < Y_ELEMS; e++) y_mem[e] <= '0;
    end else if (clear) begin
      h_ptr <= '0;
      y_ptr <= '0;
    end else if (wr_en) begin
      if (h_wr_valid && !h_full) begin
        h_mem[h_ptr[K_W-1:0]] <= h_wr_data;
        h_ptr                 <= h_ptr + 1'b1;
      end
      if (y_wr_valid && !y_full) begin
        y_mem[y_ptr[YK_W-1:0]] <= y_wr_data;
        y_ptr                  <= y_ptr + 1'b1;
      end
    end
  end

  // Y replay is shorter than H; beyond its end the stream reads as zero.
  assign h_rd = h_mem[rd_k];
  assign y_rd = (rd_k < K_W'(Y_ELEMS)) ? y_mem[rd_k[YK_W-1:0]] : '0;

endmodule

// File: rtl/xcalc_scheduler.sv
// Frame sequencer: buffers H/Y, sweeps q over x_calculate and hands results downstream.
// Optional q_done watchdog with sticky timeout_err when XSCHED_TIMEOUT_EN is defined.
module xcalc_scheduler
  import xcalc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           h_wr_valid,
  input  logic [N-1:0]   h_wr_r,
  input  logic [N-1:0]   h_wr_i,
  input  logic           y_wr_valid,
  input  logic [N-1:0]   y_wr_r,
  input  logic [N-1:0]   y_wr_i,
  input  logic           start,
  output logic           buf_full,
  output logic           busy,
  output logic           frame_done,
  output logic           xc_start_new_q,
  output logic [3:0]     xc_q_index,
  output logic           xc_H_in_valid,
  output logic [N-1:0]   xc_H_in_r,
  output logic [N-1:0]   xc_H_in_i,
  output logic           xc_Y_in_valid,
  output logic [N-1:0]   xc_Y_in_r,
  output logic [N-1:0]   xc_Y_in_i,
  input  logic           xc_q_done,
  input  logic [N-1:0]   xc_xI1,
  input  logic [N-1:0]   xc_xQ1,
  input  logic [N-1:0]   xc_xI2,
  input  logic [N-1:0]   xc_xQ2,
`ifdef XSCHED_TIMEOUT_EN
  output logic           timeout_err,
`endif
  output logic           res_valid,
  input  logic           res_ready,
  output logic [3:0]     res_q_index,
  output logic [N-1:0]   res_xI1,
  output logic [N-1:0]   res_xQ1,
  output logic [N-1:0]   res_xI2,
  output logic [N-1:0]   res_xQ2
);

  xc_state_t      state, state_nxt;
  logic [Q_W-1:0] q;
  logic [K_W-1:0] k;
  logic           done_sticky;
  logic           capture, advance, clear_buf;
  logic           h_full, y_full;
  logic           last_q;
  cplx_t          h_rd, y_rd;

`ifdef XSCHED_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_fire;
`endif

  xcalc_sample_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (state == S_IDLE),
    .clear      (clear_buf),
    .h_wr_valid (h_wr_valid),
    .h_wr_data  ({h_wr_r, h_wr_i}),
    .y_wr_valid (y_wr_valid),
    .y_wr_data  ({y_wr_r, y_wr_i}),
    .rd_k       (k),
    .h_rd       (h_rd),
    .y_rd       (y_rd),
    .h_full     (h_full),
    .y_full     (y_full)
  );

  assign buf_full   = h_full && y_full;
  assign busy       = (state != S_IDLE);
  assign xc_q_index = 4'(q);
  assign last_q     = (q == Q_W'(NUM_Q - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    advance        = 1'b0;
    clear_buf      = 1'b0;
    xc_start_new_q = 1'b0;
    xc_H_in_valid  = 1'b0;
    xc_Y_in_valid  = 1'b0;
    res_valid      = 1'b0;
    frame_done     = 1'b0;
`ifdef XSCHED_TIMEOUT_EN
    to_fire        = 1'b0;
`endif
    case (state)
      S_IDLE:  if (start && buf_full) state_nxt = S_START;
      S_START: begin
        xc_start_new_q = 1'b1;
        state_nxt      = S_STREAM;
      end
      S_STREAM: begin
        xc_H_in_valid = 1'b1;
        xc_Y_in_valid = (k < K_W'(Y_ELEMS));
        if (k == K_W'(H_ELEMS - 1)) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (xc_q_done || done_sticky) begin
          capture   = 1'b1;
          state_nxt = S_EMIT;
        end
`ifdef XSCHED_TIMEOUT_EN
        // A timed-out q is dropped and the sweep moves on as if it were accepted.
        else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          to_fire   = 1'b1;
          advance   = 1'b1;
          state_nxt = last_q ? S_FINISH : S_START;
        end
`endif
      end
      S_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          advance   = 1'b1;
          state_nxt = last_q ? S_FINISH : S_START;
        end
      end
      S_FINISH: begin
        frame_done = 1'b1;
        clear_buf  = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q           <= '0;
      k           <= '0;
      done_sticky <= 1'b0;
      res_q_index <= '0;
      res_xI1     <= '0;
      res_xQ1     <= '0;
      res_xI2     <= '0;
      res_xQ2     <= '0;
    end else begin
      if (state == S_STREAM) k <= (k == K_W'(H_ELEMS - 1)) ? '0 : k + 1'b1;
      else                   k <= '0;

      // q_done may arrive while H/Y are still streaming; hold it for WAIT_DONE.
      if (state == S_START)                 done_sticky <= 1'b0;
      else if (state != S_IDLE && xc_q_done) done_sticky <= 1'b1;

      if (state == S_FINISH) q <= '0;
      else if (advance)      q <= last_q ? '0 : q + 1'b1;

      if (capture) begin
        res_q_index <= 4'(q);
        res_xI1     <= xc_xI1;
        res_xQ1     <= xc_xQ1;
        res_xI2     <= xc_xI2;
        res_xQ2     <= xc_xQ2;
      end
    end
  end

  always_comb begin
    xc_H_in_r = '0;
    xc_H_in_i = '0;
    xc_Y_in_r = '0;
    xc_Y_in_i = '0;
    if (xc_H_in_valid) begin
      xc_H_in_r = h_rd.r;
      xc_H_in_i = h_rd.i;
    end
    if (xc_Y_in_valid) begin
      xc_Y_in_r = y_rd.r;
      xc_Y_in_i = y_rd.i;
    end
  end

`ifdef XSCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_START)          to_cnt <= '0;
      else if (state == S_WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      if (to_fire) timeout_err <= 1'b1;
    end
  end
`endif

endmodule
